dff_deserializer: RTL and testbench
===================================

Name: dff_deserializer

Overview:
- Downstream consumer of the D flip-flop stage: samples the registered bit stream (DFF q) whenever its strobe is high.
- Assembles WIDTH-bit words and presents them on a valid/ready output port.
- Provides two words of buffering (output register plus one pending register) because the bit input has no backpressure.
- Flags dropped words with a sticky overflow bit.

Parameters:
- WIDTH, 8, bits per assembled word; legal range 2..32.
- MSB_FIRST, 0. 0: first accepted bit lands in word bit 0. 1: first accepted bit lands in word bit WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset (asserts immediately, deasserts synchronously to clk upstream).
- clear  input  1  synchronous flush; has priority over all other inputs.
- bit_in  input  1  serial data; driven by DFF q.
- bit_valid  input  1  bit_in is accepted on any rising edge where this is high.
- word_out  output  WIDTH  assembled word; stable while word_valid=1 and word_ready=0.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out on an edge where word_valid=1 and word_ready=1.
- bit_count  output  $clog2(WIDTH+1)  number of bits in the partial word (0..WIDTH-1).
- overflow  output  1  sticky; set when a completed word is dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - word_out=0, word_valid=0, bit_count=0, overflow=0.
  - Shift register and pending register cleared; state=EMPTY.
- clear=1 at an edge:
  - Same result as reset.
  - Any bit presented that cycle is ignored.
  - Any handshake that cycle is discarded; the consumer must not count it.
- Bit accept (bit_valid=1):
  - The bit is written at position bit_count (LSB-first) or WIDTH-1-bit_count (MSB-first).
  - bit_count increments.
  - On the WIDTH-th bit the word is complete: bit_count returns to 0 at that edge, and the completed word includes the current bit_in.
- States, buffer occupancy:
  - EMPTY: no word held.
  - ONE: output register valid.
  - TWO: output register valid and pending register full.
  - word_valid=1 in ONE and TWO.
- Transitions, evaluated per edge. "complete" = word completes this edge; "take" = word_valid & word_ready.
  - EMPTY + complete -> ONE; word_out loaded. Latency: word_valid rises at the edge accepting the last bit, visible the following cycle.
  - ONE + take + no complete -> EMPTY.
  - ONE + take + complete -> ONE; word_out loaded with the new word (back-to-back, no bubble).
  - ONE + no take + complete -> TWO; new word into pending register.
  - TWO + take + no complete -> ONE; pending moves to word_out.
  - TWO + take + complete -> TWO; pending moves to word_out, new word into pending register.
  - TWO + no take + complete -> TWO; new word dropped, overflow set, existing words unchanged.
- Ordering: words leave in completion order.
- overflow: cleared only by rst or clear.
- Partial words: collection of the next word continues in every state, including TWO; bits are never dropped individually.
- Consumer rule: word_ready while word_valid=0 has no effect.
- Bounds: bit_count never equals WIDTH at an output.
- Coverage: code contains cover properties for back-to-back completion with take, and for the overflow drop.

Test Plan:
- WIDTH=8, LSB-first, word_ready=1; bits 1,0,1,1,0,0,1,0 on consecutive cycles -> word_valid=1 for exactly one cycle with word_out=0x4D, one cycle after the 8th bit; bit_count=0.
- MSB_FIRST=1, same bit sequence -> word_out=0xB2.
- word_ready=0; three consecutive words 0x11, 0x22, 0x33 -> state TWO, overflow=1, word_out=0x11. Then word_ready=1 -> 0x11 followed by 0x22 on consecutive handshakes; 0x33 is never output.
- bit_valid gapped (every third cycle) with 0xA5 LSB-first -> word_out=0xA5; bit_count steps 0..7 and holds during gaps.
- 5 bits accepted, then clear=1 with bit_valid=1 -> bit_count=0, word_valid=0, overflow=0. A following clean 8-bit 0x3C -> word_out=0x3C.
- rst asserted mid-word, asynchronously between edges with word_valid=1 -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/dff_deserializer.sv
// -----------------------------------------------------------------------------
// dff_deserializer
//
// Samples a registered serial bit stream whenever bit_valid is high and
// packs the bits into WIDTH-bit words. Completed words are presented on a
// valid/ready port. The bit input cannot be stalled, so two words are
// buffered: the output register and one pending register. A word that
// completes while both are full is dropped, and the sticky overflow flag
// is set.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  0: the first bit lands in word bit 0
//              1: the first bit lands in word bit WIDTH-1
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   clear       synchronous flush; overrides every other input
//   bit_in      serial data (DFF q)
//   bit_valid   accept bit_in on this edge
//   word_out    assembled word; held while word_valid & !word_ready
//   word_valid  word_out holds an unconsumed word
//   word_ready  consumer takes word_out when word_valid is also high
//   bit_count   number of bits in the partial word (0..WIDTH-1)
//   overflow    sticky flag; a completed word was dropped
// -----------------------------------------------------------------------------
module dff_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CW-1:0]    bit_count,
  output logic             overflow
);

  // Buffer occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state,    state_nx;
  logic [WIDTH-1:0] shreg,    shreg_nx;
  logic [WIDTH-1:0] out_q,    out_nx;
  logic [WIDTH-1:0] pend_q,   pend_nx;
  logic [CW-1:0]    cnt,      cnt_nx;
  logic             ovf_q,    ovf_nx;

  logic [CW-1:0]    pos;
  logic [WIDTH-1:0] word_new;
  logic             complete;
  logic             take;

  // Bit position written by the current bit.
  assign pos = MSB_FIRST ? (LAST - cnt) : cnt;

  // Partial word with the current bit already merged in, so a completing
  // word includes the bit accepted on that same edge.
  always_comb begin
    word_new = shreg;
    for (int i = 0; i < WIDTH; i++) begin
      if (pos == CW'(i)) word_new[i] = bit_in;
    end
  end

  assign complete   = bit_valid && (cnt == LAST);
  assign word_valid = (state != EMPTY);
  assign take       = word_valid && word_ready;

  // Next-state and datapath.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nx = state;
    shreg_nx = shreg;
    out_nx   = out_q;
    pend_nx  = pend_q;
    cnt_nx   = cnt;
    ovf_nx   = ovf_q;

    // Collection continues in every state; bits are never dropped.
    if (bit_valid) begin
      if (complete) begin
        shreg_nx = '0;
        cnt_nx   = '0;
      end else begin
        shreg_nx = word_new;
        cnt_nx   = cnt + 1'b1;
      end
    end

    unique case (state)
      EMPTY: begin
        if (complete) begin
          state_nx = ONE;
          out_nx   = word_new;
        end
      end
      ONE: begin
        if (take && !complete) begin
          state_nx = EMPTY;
        end else if (take && complete) begin
          out_nx   = word_new;           // back-to-back, no bubble
        end else if (complete) begin
          state_nx = TWO;
          pend_nx  = word_new;
        end
      end
      TWO: begin
        if (take && !complete) begin
          state_nx = ONE;
          out_nx   = pend_q;
        end else if (take && complete) begin
          out_nx   = pend_q;
          pend_nx  = word_new;
        end else if (complete) begin
          ovf_nx   = 1'b1;               // new word dropped, buffers kept
        end
      end
      default: state_nx = EMPTY;
    endcase

    // Flush overrides everything, including a handshake this cycle.
    if (clear) begin
      state_nx = EMPTY;
      shreg_nx = '0;
      out_nx   = '0;
      pend_nx  = '0;
      cnt_nx   = '0;
      ovf_nx   = 1'b0;
    end
  end

  // NOTE: the pending register is reset along with the rest even though it
  // is only read after being written; this keeps every register in a known
  // state and makes reset and clear identical.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      shreg  <= '0;
      out_q  <= '0;
      pend_q <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state  <= state_nx;
      shreg  <= shreg_nx;
      out_q  <= out_nx;
      pend_q <= pend_nx;
      cnt    <= cnt_nx;
      ovf_q  <= ovf_nx;
    end
  end

  assign word_out  = out_q;
  assign bit_count = cnt;
  assign overflow  = ovf_q;

  // The partial-word counter wraps at WIDTH-1 and never shows WIDTH.
  a_count_bound : assert property (@(posedge clk) disable iff (!rst)
    cnt <= LAST);

  // Output is held while the consumer stalls.
  a_hold : assert property (@(posedge clk) disable iff (!rst)
    (word_valid && !word_ready && !clear) |=> (word_valid && $stable(word_out)));

  c_back_to_back : cover property (@(posedge clk) disable iff (!rst)
    !clear && state == ONE && take && complete);

  c_overflow_drop : cover property (@(posedge clk) disable iff (!rst)
    !clear && state == TWO && !take && complete);

endmodule

// File: tb/tb_dff_deserializer.sv
// -----------------------------------------------------------------------------
// tb_dff_deserializer
//
// Drives an LSB-first and an MSB-first instance (WIDTH=8) from the same
// inputs. A behavioural model keeps the partial word as a bit counter plus
// value and the buffered words as a queue of capacity two; the MSB-first
// expectation is the bit-reversed LSB-first word. A compare process checks
// both instances on every falling edge, and directed sequences pin the
// model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_dff_deserializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          bit_in;
  logic          bit_valid;
  logic          word_ready;

  logic [W-1:0]  wo_l, wo_m;
  logic          wv_l, wv_m;
  logic [CW-1:0] bc_l, bc_m;
  logic          ov_l, ov_m;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  dff_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .word_out(wo_l), .word_valid(wv_l),
    .word_ready(word_ready), .bit_count(bc_l), .overflow(ov_l)
  );

  dff_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in),
    .bit_valid(bit_valid), .word_out(wo_m), .word_valid(wv_m),
    .word_ready(word_ready), .bit_count(bc_m), .overflow(ov_m)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: words held in completion order, at most two.
  // ---------------------------------------------------------------------------
  int           m_n;
  logic [W-1:0] m_part;
  logic [W-1:0] m_q[$];
  bit           m_ovf;

  task automatic model_reset();
    m_n    = 0;
    m_part = '0;
    m_q.delete();
    m_ovf  = 1'b0;
  endtask

  task automatic model_step();
    bit tk;
    if (clear) begin
      model_reset();
      return;
    end
    tk = (m_q.size() > 0) && word_ready;
    if (tk) void'(m_q.pop_front());
    if (bit_valid) begin
      m_part[m_n] = bit_in;
      m_n++;
      if (m_n == W) begin
        if (m_q.size() < 2) m_q.push_back(m_part);
        else                m_ovf = 1'b1;
        m_n    = 0;
        m_part = '0;
      end
    end
  endtask

  always @(negedge rst) model_reset();
  always @(posedge clk) if (rst) model_step();

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst && cmp_en) begin
      check("valid_l", wv_l, m_q.size() > 0);
      check("valid_m", wv_m, m_q.size() > 0);
      check("count_l", bc_l, m_n);
      check("count_m", bc_m, m_n);
      check("ovf_l",   ov_l, m_ovf);
      check("ovf_m",   ov_m, m_ovf);
      if (m_q.size() > 0) begin
        check("word_l", wo_l, m_q[0]);
        check("word_m", wo_m, rev(m_q[0]));
      end
    end
  end

  // Shift out n bits of w, LSB of w first, one per cycle.
  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_in    = w[i];
      bit_valid = 1'b1;
    end
  endtask

  initial begin
    rst        = 1'b0;
    clear      = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b1;
    model_reset();

    // Reset state.
    #12;
    check("rst_word",  wo_l, 0);
    check("rst_valid", wv_l, 0);
    check("rst_count", bc_l, 0);
    check("rst_ovf",   ov_l, 0);
    @(negedge clk);
    rst    = 1'b1;
    cmp_en = 1'b1;

    // Bits 1,0,1,1,0,0,1,0 with word_ready=1: one-cycle word.
    send_bits(8'b0100_1101, 8);
    @(negedge clk);
    bit_valid = 1'b0;
    check("t1_valid", wv_l, 1);
    check("t1_word_lsb", wo_l, 8'h4D);
    check("t1_word_msb", wo_m, 8'hB2);
    check("t1_count", bc_l, 0);
    @(negedge clk);
    check("t1_one_cycle", wv_l, 0);

    // Three words with no consumer: 0x33 dropped.
    word_ready = 1'b0;
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    @(negedge clk);
    bit_valid = 1'b0;
    check("t3_ovf", ov_l, 1);
    check("t3_word_lsb", wo_l, 8'h11);
    check("t3_word_msb", wo_m, 8'h88);
    word_ready = 1'b1;
    @(negedge clk);
    check("t3_second", wo_l, 8'h22);
    check("t3_second_valid", wv_l, 1);
    @(negedge clk);
    check("t3_drained", wv_l, 0);
    check("t3_ovf_sticky", ov_l, 1);

    // 0xA5 with a bit every third cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_count_pre", bc_l, i);
      bit_in    = 1'((8'hA5 >> i) & 1);
      bit_valid = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
      check("t4_count_step", bc_l, (i + 1) % 8);
      if (i == 7) check("t4_word", wo_l, 8'hA5);
      @(negedge clk);
      check("t4_count_hold", bc_l, (i + 1) % 8);
    end

    // Partial word then clear with a bit presented.
    send_bits(8'h1F, 5);
    @(negedge clk);
    clear  = 1'b1;
    bit_in = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    bit_valid = 1'b0;
    check("t5_count", bc_l, 0);
    check("t5_valid", wv_l, 0);
    check("t5_ovf",   ov_l, 0);
    send_bits(8'h3C, 8);
    @(negedge clk);
    bit_valid = 1'b0;
    check("t5_word_lsb", wo_l, 8'h3C);
    check("t5_word_msb", wo_m, 8'h3C);

    // Asynchronous reset between edges while a word is held.
    word_ready = 1'b0;
    send_bits(8'h5A, 8);
    send_bits(8'h07, 3);
    @(negedge clk);
    bit_valid = 1'b0;
    check("t6_pre_valid", wv_l, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_word",  wo_l, 0);
    check("t6_valid", wv_l, 0);
    check("t6_count", bc_l, 0);
    check("t6_ovf",   ov_l, 0);
    check("t6_valid_m", wv_m, 0);
    @(negedge clk);
    rst        = 1'b1;
    word_ready = 1'b1;

    // Randomised traffic with varying consumer pressure.
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        bit_in     = 1'($urandom_range(0, 1));
        bit_valid  = ($urandom_range(0, 3) != 0);
        word_ready = (blk % 3 == 0) ? ($urandom_range(0, 7) == 0)
                                    : ($urandom_range(0, 3) != 0);
        clear      = ($urandom_range(0, 299) == 0);
      end
    end
    @(negedge clk);
    clear     = 1'b0;
    bit_valid = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
